// File: rtl/bs_tap_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bs_tap_chain_pkg
//  Description : Shared TAP state encoding, instruction codes and the TAP
//                next-state function for the boundary-scan TAP chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package bs_tap_chain_pkg;

  // IEEE 1149.1 state encoding; the values are visible on TapState.
  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  // Instruction codes. BYPASS is all ones at whatever IR width is used, so
  // it is built in the instantiating module; unknown codes act as BYPASS.
  localparam int unsigned INSTR_EXTEST         = 0;
  localparam int unsigned INSTR_SAMPLE_PRELOAD = 1;

  // Low two bits captured into the IR shift register in Capture-IR: the
  // 1149.1 fixed pattern (bit0 = 1, bit1 = 0), upper bits zero.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  // Standard TMS-driven TAP state transition.
  function automatic tap_state_t tap_next_state(input tap_state_t cur,
                                                input logic       tms);
    tap_state_t nxt;
    nxt = TAP_TLR;
    case (cur)
      TAP_TLR:     nxt = tms ? TAP_TLR     : TAP_RTI;
      TAP_RTI:     nxt = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELDR:   nxt = tms ? TAP_SELIR   : TAP_CAPDR;
      TAP_CAPDR:   nxt = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_SHDR:    nxt = tms ? TAP_EX1DR   : TAP_SHDR;
      TAP_EX1DR:   nxt = tms ? TAP_UPDDR   : TAP_PAUSEDR;
      TAP_PAUSEDR: nxt = tms ? TAP_EX2DR   : TAP_PAUSEDR;
      TAP_EX2DR:   nxt = tms ? TAP_UPDDR   : TAP_SHDR;
      TAP_UPDDR:   nxt = tms ? TAP_SELDR   : TAP_RTI;
      TAP_SELIR:   nxt = tms ? TAP_TLR     : TAP_CAPIR;
      TAP_CAPIR:   nxt = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_SHIR:    nxt = tms ? TAP_EX1IR   : TAP_SHIR;
      TAP_EX1IR:   nxt = tms ? TAP_UPDIR   : TAP_PAUSEIR;
      TAP_PAUSEIR: nxt = tms ? TAP_EX2IR   : TAP_PAUSEIR;
      TAP_EX2IR:   nxt = tms ? TAP_UPDIR   : TAP_SHIR;
      TAP_UPDIR:   nxt = tms ? TAP_SELDR   : TAP_RTI;
      default:     nxt = TAP_TLR;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bs_tap_chain_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : bs_tap_chain_fsm
//  Description : IEEE 1149.1 TAP controller. Tracks TMS on rising TCLK and
//                decodes the per-state capture/shift/update strobes used by
//                the instruction and data registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module bs_tap_chain_fsm
  import bs_tap_chain_pkg::*;
(
  input  logic       tclk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state,
  output logic       test_logic_reset,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_t cur_state;
  tap_state_t nxt_state;

  // State register: reset forces Test-Logic-Reset asynchronously.
  always_ff @(posedge tclk or posedge rst) begin
    if (rst) begin
      cur_state <= TAP_TLR;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic from the shared transition function.
  always_comb begin
    nxt_state = tap_next_state(cur_state, tms);
  end

  // Strobe decode: each strobe is high for the whole cycle spent in its state.
  always_comb begin
    test_logic_reset = 1'b0;
    capture_dr       = 1'b0;
    shift_dr         = 1'b0;
    update_dr        = 1'b0;
    capture_ir       = 1'b0;
    shift_ir         = 1'b0;
    update_ir        = 1'b0;
    case (cur_state)
      TAP_TLR:   test_logic_reset = 1'b1;
      TAP_CAPDR: capture_dr       = 1'b1;
      TAP_SHDR:  shift_dr         = 1'b1;
      TAP_UPDDR: update_dr        = 1'b1;
      TAP_CAPIR: capture_ir       = 1'b1;
      TAP_SHIR:  shift_ir         = 1'b1;
      TAP_UPDIR: update_ir        = 1'b1;
      default:   ;
    endcase
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: rtl/bs_tap_chain.sv
`default_nettype none
// ============================================================================
//  Module      : bs_tap_chain
//  Description : Boundary-scan TAP with instruction register, bypass register
//                and a Length-cell boundary-scan register (capture + update
//                stage per cell). Supports EXTEST, SAMPLE/PRELOAD and BYPASS.
//  Revision    : 1.0 - initial release
// ============================================================================
module bs_tap_chain
  import bs_tap_chain_pkg::*;
#(
  parameter int Length = 8,
  parameter int IR_W   = 3
)
(
  input  logic              TCLK,
  input  logic              Rst,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_en,
  input  logic [Length-1:0] Din,
  output logic [Length-1:0] Dout,
  output logic [IR_W-1:0]   IR,
  output logic [3:0]        TapState
);

  localparam logic [IR_W-1:0] IR_BYPASS  = '1;
  localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(INSTR_EXTEST);
  localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(INSTR_SAMPLE_PRELOAD);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);

  tap_state_t tap_state;
  logic       test_logic_reset;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       capture_ir;
  logic       shift_ir;
  logic       update_ir;

  logic [IR_W-1:0]   ir_shift;
  logic [IR_W-1:0]   ir_reg;
  logic [IR_W-1:0]   active_ir;
  logic              bsr_selected;
  logic              extest_active;
  logic              bypass_reg;
  logic              bsr_capture_en;
  logic              bsr_shift_en;
  logic              bsr_update_en;
  logic [Length-1:0] bsr_capture;
  logic [Length-1:0] bsr_update;
  logic [Length-1:0] bsr_shift_in;
  logic              tdo_bit;

  bs_tap_chain_fsm u_fsm (
    .tclk             (TCLK),
    .rst              (Rst),
    .tms              (TMS),
    .state            (tap_state),
    .test_logic_reset (test_logic_reset),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  // ---------------------------------------------------------------------------
  // Instruction register
  // ---------------------------------------------------------------------------

  // IR shift stage: fixed pattern in Capture-IR, shift right toward TDO in Shift-IR.
  always_ff @(posedge TCLK or posedge Rst) begin
    if (Rst) begin
      ir_shift <= '0;
    end else if (capture_ir) begin
      ir_shift <= IR_CAPTURE;
    end else if (shift_ir) begin
      ir_shift <= {TDI, ir_shift[IR_W-1:1]};
    end
  end

  // Active instruction: BYPASS while in TLR, loaded only in Update-IR.
  always_ff @(posedge TCLK or posedge Rst) begin
    if (Rst) begin
      ir_reg <= IR_BYPASS;
    end else if (test_logic_reset) begin
      ir_reg <= IR_BYPASS;
    end else if (update_ir) begin
      ir_reg <= ir_shift;
    end
  end

  // Entering TLR via TMS takes effect on the instruction immediately, not a
  // cycle later, so the decode sees BYPASS for the whole TLR stay.
  assign active_ir     = test_logic_reset ? IR_BYPASS : ir_reg;
  assign bsr_selected  = (active_ir == IR_EXTEST) || (active_ir == IR_SAMPLE);
  assign extest_active = (active_ir == IR_EXTEST);

  // ---------------------------------------------------------------------------
  // Bypass register
  // ---------------------------------------------------------------------------

  // One-bit bypass: captures 0, then delays TDI by one cycle while shifting.
  always_ff @(posedge TCLK or posedge Rst) begin
    if (Rst) begin
      bypass_reg <= 1'b0;
    end else if (capture_dr && !bsr_selected) begin
      bypass_reg <= 1'b0;
    end else if (shift_dr && !bsr_selected) begin
      bypass_reg <= TDI;
    end
  end

  // ---------------------------------------------------------------------------
  // Boundary-scan register
  // ---------------------------------------------------------------------------

  assign bsr_capture_en = capture_dr && bsr_selected;
  assign bsr_shift_en   = shift_dr   && bsr_selected;
  assign bsr_update_en  = update_dr  && bsr_selected;

  // Serial input of each cell: TDI enters the top cell, the chain shifts toward cell 0.
  assign bsr_shift_in = {TDI, bsr_capture[Length-1:1]};

  for (genvar i = 0; i < Length; i++) begin : g_bsr_cell
    logic cap_bit;
    logic upd_bit;

    // Capture stage: parallel load of the core-side pin, or serial shift.
    always_ff @(posedge TCLK or posedge Rst) begin
      if (Rst) begin
        cap_bit <= 1'b0;
      end else if (bsr_capture_en) begin
        cap_bit <= Din[i];
      end else if (bsr_shift_en) begin
        cap_bit <= bsr_shift_in[i];
      end
    end

    // Update stage: holds the last updated value across IR changes so a
    // PRELOAD survives the switch to EXTEST.
    always_ff @(posedge TCLK or posedge Rst) begin
      if (Rst) begin
        upd_bit <= 1'b0;
      end else if (bsr_update_en) begin
        upd_bit <= cap_bit;
      end
    end

    assign bsr_capture[i] = cap_bit;
    assign bsr_update[i]  = upd_bit;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // TDO mux: LSB of whichever shift path is active, forced low otherwise.
  always_comb begin
    tdo_bit = 1'b0;
    if (shift_ir) begin
      tdo_bit = ir_shift[0];
    end else if (shift_dr) begin
      tdo_bit = bsr_selected ? bsr_capture[0] : bypass_reg;
    end
  end

  assign TDO      = tdo_bit;
  assign TDO_en   = shift_dr || shift_ir;
  assign Dout     = extest_active ? bsr_update : Din;
  assign IR       = active_ir;
  assign TapState = tap_state;

endmodule
`default_nettype wire
